// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 widths and types for the write-channel arbiter.
// Holds the arbiter FSM state encoding and the default outstanding depth.
package axi4_globals_pkg;

  localparam int unsigned ADDRESS_WIDTH       = 32;
  localparam int unsigned DATA_WIDTH          = 32;
  localparam int unsigned ID_WIDTH            = 4;
  localparam int unsigned USER_WIDTH          = 1;
  localparam int unsigned DEFAULT_OUTST_DEPTH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } axi4_wr_arb_state_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]      id;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic                     lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               qos;
    logic [3:0]               region;
    logic [USER_WIDTH-1:0]    user;
  } axi4_aw_t;

endpackage

// File: rtl/axi4_arb_id_fifo.sv
// Synchronous FIFO of requester indices; records who owns each outstanding write
// so B responses can be routed back in issue order.
module axi4_arb_id_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when a pop frees a slot the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axi4_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ AXI4 write masters onto one slave port,
// with in-order B routing bounded by OUTST_DEPTH outstanding bursts.
module axi4_wr_arbiter
  import axi4_globals_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned OUTST_DEPTH = DEFAULT_OUTST_DEPTH
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [ID_WIDTH-1:0]      s_awid     [NUM_REQ],
  input  logic [ADDRESS_WIDTH-1:0] s_awaddr   [NUM_REQ],
  input  logic [7:0]               s_awlen    [NUM_REQ],
  input  logic [2:0]               s_awsize   [NUM_REQ],
  input  logic [1:0]               s_awburst  [NUM_REQ],
  input  logic                     s_awlock   [NUM_REQ],
  input  logic [3:0]               s_awcache  [NUM_REQ],
  input  logic [2:0]               s_awprot   [NUM_REQ],
  input  logic [3:0]               s_awqos    [NUM_REQ],
  input  logic [3:0]               s_awregion [NUM_REQ],
  input  logic [USER_WIDTH-1:0]    s_awuser   [NUM_REQ],
  input  logic [NUM_REQ-1:0]       s_awvalid,
  output logic [NUM_REQ-1:0]       s_awready,
  input  logic [DATA_WIDTH-1:0]    s_wdata    [NUM_REQ],
  input  logic [DATA_WIDTH/8-1:0]  s_wstrb    [NUM_REQ],
  input  logic                     s_wlast    [NUM_REQ],
  input  logic [USER_WIDTH-1:0]    s_wuser    [NUM_REQ],
  input  logic [NUM_REQ-1:0]       s_wvalid,
  output logic [NUM_REQ-1:0]       s_wready,
  output logic [ID_WIDTH-1:0]      s_bid,
  output logic [1:0]               s_bresp,
  output logic [USER_WIDTH-1:0]    s_buser,
  output logic [NUM_REQ-1:0]       s_bvalid,
  input  logic [NUM_REQ-1:0]       s_bready,
  output logic [ID_WIDTH-1:0]      m_awid,
  output logic [ADDRESS_WIDTH-1:0] m_awaddr,
  output logic [7:0]               m_awlen,
  output logic [2:0]               m_awsize,
  output logic [1:0]               m_awburst,
  output logic                     m_awlock,
  output logic [3:0]               m_awcache,
  output logic [2:0]               m_awprot,
  output logic [3:0]               m_awqos,
  output logic [3:0]               m_awregion,
  output logic [USER_WIDTH-1:0]    m_awuser,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [DATA_WIDTH-1:0]    m_wdata,
  output logic [DATA_WIDTH/8-1:0]  m_wstrb,
  output logic                     m_wlast,
  output logic [USER_WIDTH-1:0]    m_wuser,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  input  logic [ID_WIDTH-1:0]      m_bid,
  input  logic [1:0]               m_bresp,
  input  logic [USER_WIDTH-1:0]    m_buser,
  input  logic                     m_bvalid,
  output logic                     m_bready
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  axi4_wr_arb_state_e state_q, state_d;
  axi4_aw_t           aw_hold_q, aw_in;
  // The most recent grant is also the owner of the burst in ADDR/DATA.
  logic [IdxW-1:0]    last_grant_q;
  logic [IdxW-1:0]    rr_idx, fifo_head;
  logic               rr_found, aw_load;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;

  always_comb begin
    logic [IdxW-1:0] cand;
    cand     = '0;
    rr_found = 1'b0;
    rr_idx   = last_grant_q;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((32'(last_grant_q) + i) % NUM_REQ);
      if (!rr_found && s_awvalid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin
    aw_in = '{id: s_awid[rr_idx], addr: s_awaddr[rr_idx], len: s_awlen[rr_idx],
              size: s_awsize[rr_idx], burst: s_awburst[rr_idx], lock: s_awlock[rr_idx],
              cache: s_awcache[rr_idx], prot: s_awprot[rr_idx], qos: s_awqos[rr_idx],
              region: s_awregion[rr_idx], user: s_awuser[rr_idx]};
  end

  always_comb begin
    state_d   = state_q;
    s_awready = '0;
    s_wready  = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    aw_load   = 1'b0;
    fifo_push = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gating on aresetn keeps s_awready low while reset is held.
        if (aresetn && rr_found && !fifo_full) begin
          s_awready[rr_idx] = 1'b1;
          aw_load           = 1'b1;
          state_d           = StAddr;
        end
      end
      StAddr: begin
        m_awvalid = 1'b1;
        if (m_awready) begin
          fifo_push = 1'b1;
          state_d   = StData;
        end
      end
      StData: begin
        m_wvalid               = s_wvalid[last_grant_q];
        s_wready[last_grant_q] = m_wready;
        if (s_wvalid[last_grant_q] && m_wready && m_wlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      aw_hold_q    <= '0;
    end else begin
      state_q <= state_d;
      if (aw_load) begin
        aw_hold_q    <= aw_in;
        last_grant_q <= rr_idx;
      end
    end
  end

  assign m_awid     = aw_hold_q.id;
  assign m_awaddr   = aw_hold_q.addr;
  assign m_awlen    = aw_hold_q.len;
  assign m_awsize   = aw_hold_q.size;
  assign m_awburst  = aw_hold_q.burst;
  assign m_awlock   = aw_hold_q.lock;
  assign m_awcache  = aw_hold_q.cache;
  assign m_awprot   = aw_hold_q.prot;
  assign m_awqos    = aw_hold_q.qos;
  assign m_awregion = aw_hold_q.region;
  assign m_awuser   = aw_hold_q.user;

  assign m_wdata = s_wdata[last_grant_q];
  assign m_wstrb = s_wstrb[last_grant_q];
  assign m_wlast = s_wlast[last_grant_q];
  assign m_wuser = s_wuser[last_grant_q];

  assign s_bid    = m_bid;
  assign s_bresp  = m_bresp;
  assign s_buser  = m_buser;
  assign m_bready = !fifo_empty && s_bready[fifo_head];
  assign fifo_pop = m_bvalid && m_bready;

  always_comb begin
    s_bvalid = '0;
    if (!fifo_empty) s_bvalid[fifo_head] = m_bvalid;
  end

  axi4_arb_id_fifo #(
    .Depth(OUTST_DEPTH),
    .Width(IdxW)
  ) u_id_fifo (
    .clk      (aclk),
    .rst_n    (aresetn),
    .push     (fifo_push),
    .push_data(last_grant_q),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Directed bench for axi4_wr_arbiter: arbitration order, W isolation, B routing,
// outstanding limit, AW backpressure stability and mid-burst reset.
module tb_axi4_wr_arbiter;
  import axi4_globals_pkg::*;

  localparam int NR = 2;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [ID_WIDTH-1:0]      s_awid     [NR];
  logic [ADDRESS_WIDTH-1:0] s_awaddr   [NR];
  logic [7:0]               s_awlen    [NR];
  logic [2:0]               s_awsize   [NR];
  logic [1:0]               s_awburst  [NR];
  logic                     s_awlock   [NR];
  logic [3:0]               s_awcache  [NR];
  logic [2:0]               s_awprot   [NR];
  logic [3:0]               s_awqos    [NR];
  logic [3:0]               s_awregion [NR];
  logic [USER_WIDTH-1:0]    s_awuser   [NR];
  logic [NR-1:0]            s_awvalid, s_awready;
  logic [DATA_WIDTH-1:0]    s_wdata    [NR];
  logic [DATA_WIDTH/8-1:0]  s_wstrb    [NR];
  logic                     s_wlast    [NR];
  logic [USER_WIDTH-1:0]    s_wuser    [NR];
  logic [NR-1:0]            s_wvalid, s_wready;
  logic [ID_WIDTH-1:0]      s_bid;
  logic [1:0]               s_bresp;
  logic [USER_WIDTH-1:0]    s_buser;
  logic [NR-1:0]            s_bvalid, s_bready;
  logic [ID_WIDTH-1:0]      m_awid;
  logic [ADDRESS_WIDTH-1:0] m_awaddr;
  logic [7:0]               m_awlen;
  logic [2:0]               m_awsize;
  logic [1:0]               m_awburst;
  logic                     m_awlock;
  logic [3:0]               m_awcache;
  logic [2:0]               m_awprot;
  logic [3:0]               m_awqos;
  logic [3:0]               m_awregion;
  logic [USER_WIDTH-1:0]    m_awuser;
  logic                     m_awvalid, m_awready;
  logic [DATA_WIDTH-1:0]    m_wdata;
  logic [DATA_WIDTH/8-1:0]  m_wstrb;
  logic                     m_wlast;
  logic [USER_WIDTH-1:0]    m_wuser;
  logic                     m_wvalid, m_wready;
  logic [ID_WIDTH-1:0]      m_bid;
  logic [1:0]               m_bresp;
  logic [USER_WIDTH-1:0]    m_buser;
  logic                     m_bvalid, m_bready;

  int nvec = 0;
  int nfail = 0;

  axi4_wr_arbiter #(
    .NUM_REQ    (NR),
    .OUTST_DEPTH(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache),
    .s_awprot(s_awprot), .s_awqos(s_awqos), .s_awregion(s_awregion),
    .s_awuser(s_awuser), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wuser(s_wuser),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_buser(s_buser), .s_bvalid(s_bvalid),
    .s_bready(s_bready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
    .m_awprot(m_awprot), .m_awqos(m_awqos), .m_awregion(m_awregion),
    .m_awuser(m_awuser), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wuser(m_wuser),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_buser(m_buser), .m_bvalid(m_bvalid),
    .m_bready(m_bready)
  );

  function automatic logic [31:0] wd(input int r, input int b);
    return 32'hA000_0000 | (32'(r) << 16) | 32'(b);
  endfunction

  // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int r = 0; r < NR; r++) begin
      s_awid[r] = '0; s_awaddr[r] = '0; s_awlen[r] = '0; s_awsize[r] = '0;
      s_awburst[r] = '0; s_awlock[r] = 1'b0; s_awcache[r] = '0; s_awprot[r] = '0;
      s_awqos[r] = '0; s_awregion[r] = '0; s_awuser[r] = '0;
      s_wdata[r] = '0; s_wstrb[r] = '1; s_wlast[r] = 1'b0; s_wuser[r] = '0;
    end
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0;
    m_bid = '0; m_bresp = '0; m_buser = '0; m_bvalid = 1'b0;
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    clear_inputs();
    step();
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic set_aw(input int r, input logic [31:0] addr, input logic [7:0] len,
                        input logic [3:0] id);
    s_awaddr[r] = addr; s_awlen[r] = len; s_awid[r] = id;
    s_awsize[r] = 3'd2; s_awburst[r] = 2'b01;
  endtask

  // Returns the granted requester (-1 on timeout) and how many idle cycles preceded it.
  task automatic wait_grant(output int g, output int n);
    g = -1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (s_awready == 2'b01) g = 0;
      else if (s_awready == 2'b10) g = 1;
      n = i;
      step();
      if (g >= 0) break;
    end
  endtask

  task automatic accept_aw();
    m_awready = 1'b1;
    step();
    m_awready = 1'b0;
  endtask

  task automatic send_w(input int r, input int beats);
    s_wvalid[r] = 1'b1;
    m_wready = 1'b1;
    for (int b = 0; b < beats; b++) begin
      s_wdata[r] = wd(r, b);
      s_wlast[r] = (b == beats - 1);
      step();
    end
    s_wvalid[r] = 1'b0;
    s_wlast[r] = 1'b0;
    m_wready = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] rdy, output logic [1:0] seen);
    m_bvalid = 1'b1;
    s_bready = rdy;
    #1 seen = s_bvalid;
    step();
    m_bvalid = 1'b0;
    s_bready = '0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    clear_inputs();
    s_awvalid = 2'b11;
    m_bvalid = 1'b1;
    s_bready = 2'b11;
    step();
    #1;
    nvec++;
    if ({m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid} !== 9'b0) begin
      nfail++;
      $display("FAIL reset_outputs: got %b want 000000000",
               {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid});
    end
    step();
    s_awvalid = '0;
    aresetn = 1'b1;
    step();
    #1;
    nvec++;
    if ({m_bready, s_bvalid} !== 3'b000) begin
      nfail++;
      $display("FAIL stray_b_after_reset: got %b want 000", {m_bready, s_bvalid});
    end
    step();
    clear_inputs();
  endtask

  task automatic test_single();
    int g, n;
    apply_reset();
    set_aw(0, 32'h1000, 8'd3, 4'h3);
    s_awvalid[0] = 1'b1;
    wait_grant(g, n);
    s_awvalid[0] = 1'b0;
    nvec++;
    if (g !== 0) begin
      nfail++;
      $display("FAIL single_grant: got %0d want 0", g);
    end
    #1;
    nvec++;
    if ({m_awvalid, m_wvalid, m_awaddr, m_awlen, m_awid} !== {1'b1, 1'b0, 32'h1000, 8'd3, 4'h3})
    begin
      nfail++;
      $display("FAIL single_aw: got vld=%b wvld=%b addr=%h len=%0d id=%h want 1 0 1000 3 3",
               m_awvalid, m_wvalid, m_awaddr, m_awlen, m_awid);
    end
    step();
    accept_aw();
    s_wvalid[0] = 1'b1;
    m_wready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_wdata[0] = wd(0, b);
      s_wlast[0] = (b == 3);
      #1;
      nvec++;
      if ({m_wvalid, s_wready, m_wdata, m_wlast} !== {1'b1, 2'b01, wd(0, b), (b == 3)}) begin
        nfail++;
        $display("FAIL single_w_beat%0d: got vld=%b rdy=%b data=%h last=%b want 1 01 %h %b",
                 b, m_wvalid, s_wready, m_wdata, m_wlast, wd(0, b), (b == 3));
      end
      step();
    end
    s_wlast[0] = 1'b0;
    #1;
    nvec++;
    if ({m_wvalid, s_wready} !== 3'b000) begin
      nfail++;
      $display("FAIL single_w_done: got %b want 000", {m_wvalid, s_wready});
    end
    step();
    s_wvalid[0] = 1'b0;
    m_wready = 1'b0;
    m_bvalid = 1'b1;
    m_bid = 4'h3;
    m_bresp = 2'b10;
    s_bready = 2'b01;
    #1;
    nvec++;
    if ({s_bvalid, m_bready, s_bid, s_bresp} !== {2'b01, 1'b1, 4'h3, 2'b10}) begin
      nfail++;
      $display("FAIL single_b: got bvld=%b brdy=%b id=%h resp=%b want 01 1 3 10",
               s_bvalid, m_bready, s_bid, s_bresp);
    end
    step();
    s_bready = 2'b11;
    #1;
    nvec++;
    if ({s_bvalid, m_bready} !== 3'b000) begin
      nfail++;
      $display("FAIL single_b_popped: got %b want 000", {s_bvalid, m_bready});
    end
    step();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int g, n;
    logic [1:0] seen;
    aresetn = 1'b0;
    clear_inputs();
    set_aw(0, 32'h100, 8'd0, 4'h1);
    set_aw(1, 32'h200, 8'd0, 4'h2);
    s_awvalid = 2'b11;
    step();
    aresetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, n);
      nvec++;
      if (g !== k % 2) begin
        nfail++;
        $display("FAIL rr_grant%0d: got %0d want %0d", k, g, k % 2);
      end
      #1;
      nvec++;
      if (s_awready !== 2'b00) begin
        nfail++;
        $display("FAIL rr_awready_in_addr%0d: got %b want 00", k, s_awready);
      end
      step();
      accept_aw();
      send_w((g < 0) ? 0 : g, 1);
    end
    s_awvalid = '0;
    for (int k = 0; k < 4; k++) begin
      send_b(2'b11, seen);
      nvec++;
      if (seen !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        nfail++;
        $display("FAIL rr_b_route%0d: got %b want %b", k, seen, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    clear_inputs();
  endtask

  task automatic test_w_isolation();
    int g, n;
    logic [1:0] seen;
    apply_reset();
    set_aw(0, 32'h300, 8'd1, 4'h4);
    set_aw(1, 32'h400, 8'd0, 4'h5);
    s_wvalid[1] = 1'b1;
    s_wdata[1] = wd(1, 0);
    s_wlast[1] = 1'b1;
    s_awvalid[0] = 1'b1;
    wait_grant(g, n);
    s_awvalid[0] = 1'b0;
    m_wready = 1'b1;
    #1;
    nvec++;
    if ({s_wready, m_wvalid} !== 3'b000) begin
      nfail++;
      $display("FAIL iso_addr_phase: got %b want 000", {s_wready, m_wvalid});
    end
    step();
    accept_aw();
    s_wvalid[0] = 1'b1;
    for (int b = 0; b < 2; b++) begin
      s_wdata[0] = wd(0, b);
      s_wlast[0] = (b == 1);
      #1;
      nvec++;
      if ({s_wready, m_wdata} !== {2'b01, wd(0, b)}) begin
        nfail++;
        $display("FAIL iso_req0_beat%0d: got rdy=%b data=%h want 01 %h",
                 b, s_wready, m_wdata, wd(0, b));
      end
      step();
    end
    s_wvalid[0] = 1'b0;
    s_wlast[0] = 1'b0;
    #1;
    nvec++;
    if (s_wready !== 2'b00) begin
      nfail++;
      $display("FAIL iso_idle: got %b want 00", s_wready);
    end
    step();
    s_awvalid[1] = 1'b1;
    wait_grant(g, n);
    s_awvalid[1] = 1'b0;
    nvec++;
    if (g !== 1) begin
      nfail++;
      $display("FAIL iso_grant1: got %0d want 1", g);
    end
    #1;
    nvec++;
    if (s_wready !== 2'b00) begin
      nfail++;
      $display("FAIL iso_req1_addr: got %b want 00", s_wready);
    end
    step();
    accept_aw();
    #1;
    nvec++;
    if ({s_wready, m_wvalid, m_wdata} !== {2'b10, 1'b1, wd(1, 0)}) begin
      nfail++;
      $display("FAIL iso_req1_data: got rdy=%b vld=%b data=%h want 10 1 %h",
               s_wready, m_wvalid, m_wdata, wd(1, 0));
    end
    step();
    s_wvalid[1] = 1'b0;
    m_wready = 1'b0;
    send_b(2'b11, seen);
    nvec++;
    if (seen !== 2'b01) begin
      nfail++;
      $display("FAIL iso_b_first: got %b want 01", seen);
    end
    send_b(2'b11, seen);
    nvec++;
    if (seen !== 2'b10) begin
      nfail++;
      $display("FAIL iso_b_second: got %b want 10", seen);
    end
    clear_inputs();
  endtask

  task automatic test_outstanding();
    int g, n;
    int bad;
    logic [1:0] seen;
    apply_reset();
    set_aw(0, 32'h500, 8'd0, 4'h6);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      s_awvalid[0] = 1'b1;
      wait_grant(g, n);
      s_awvalid[0] = 1'b0;
      if (g != 0) bad++;
      accept_aw();
      send_w(0, 1);
    end
    nvec++;
    if (bad !== 0) begin
      nfail++;
      $display("FAIL outst_fill: got %0d missed grants want 0", bad);
    end
    s_awvalid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++;
      if (s_awready !== 2'b00) begin
        nfail++;
        $display("FAIL outst_full_block%0d: got %b want 00", i, s_awready);
      end
      step();
    end
    send_b(2'b01, seen);
    nvec++;
    if (seen !== 2'b01) begin
      nfail++;
      $display("FAIL outst_pop: got %b want 01", seen);
    end
    wait_grant(g, n);
    s_awvalid[0] = 1'b0;
    nvec++;
    if (g !== 0 || n > 1) begin
      nfail++;
      $display("FAIL outst_regrant: got req=%0d after %0d cycles want req=0 within 2", g, n);
    end
    accept_aw();
    send_w(0, 1);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      send_b(2'b01, seen);
      if (seen != 2'b01) bad++;
    end
    nvec++;
    if (bad !== 0) begin
      nfail++;
      $display("FAIL outst_drain: got %0d misrouted want 0", bad);
    end
    m_bvalid = 1'b1;
    s_bready = 2'b11;
    #1;
    nvec++;
    if ({m_bready, s_bvalid} !== 3'b000) begin
      nfail++;
      $display("FAIL outst_empty: got %b want 000", {m_bready, s_bvalid});
    end
    step();
    clear_inputs();
  endtask

  task automatic test_backpressure_reset();
    int g, n;
    apply_reset();
    set_aw(0, 32'h2000, 8'd1, 4'h5);
    s_awvalid[0] = 1'b1;
    wait_grant(g, n);
    s_awvalid[0] = 1'b0;
    s_awaddr[0] = 32'hDEAD_0000;
    s_awid[0] = 4'h9;
    s_awlen[0] = 8'd7;
    for (int i = 0; i < 5; i++) begin
      #1;
      nvec++;
      if ({m_awvalid, m_awaddr, m_awid, m_awlen} !== {1'b1, 32'h2000, 4'h5, 8'd1}) begin
        nfail++;
        $display("FAIL bp_stable%0d: got vld=%b addr=%h id=%h len=%0d want 1 2000 5 1",
                 i, m_awvalid, m_awaddr, m_awid, m_awlen);
      end
      step();
    end
    accept_aw();
    s_wvalid[0] = 1'b1;
    s_wdata[0] = wd(0, 0);
    m_wready = 1'b1;
    m_bvalid = 1'b1;
    s_bready = 2'b11;
    #1;
    nvec++;
    if ({s_wready, m_wvalid, m_bready} !== {2'b01, 1'b1, 1'b1}) begin
      nfail++;
      $display("FAIL bp_data_phase: got rdy=%b vld=%b brdy=%b want 01 1 1",
               s_wready, m_wvalid, m_bready);
    end
    aresetn = 1'b0;
    #1;
    nvec++;
    if ({m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid} !== 9'b0) begin
      nfail++;
      $display("FAIL midburst_reset: got %b want 000000000",
               {m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid});
    end
    step();
    clear_inputs();
    step();
    aresetn = 1'b1;
    m_bvalid = 1'b1;
    s_bready = 2'b11;
    #1;
    nvec++;
    if ({m_bready, s_bvalid} !== 3'b000) begin
      nfail++;
      $display("FAIL reset_fifo_empty: got %b want 000", {m_bready, s_bvalid});
    end
    step();
    m_bvalid = 1'b0;
    s_bready = '0;
    set_aw(0, 32'h600, 8'd0, 4'h1);
    set_aw(1, 32'h700, 8'd0, 4'h2);
    s_awvalid = 2'b11;
    wait_grant(g, n);
    s_awvalid = '0;
    nvec++;
    if (g !== 0) begin
      nfail++;
      $display("FAIL reset_priority: got %0d want 0", g);
    end
    step();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_w_isolation();
    test_outstanding();
    test_backpressure_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
